// File: rtl/deser_pkg.sv
// Shared constants and FSM state type for the 8-bit serial-to-parallel deserializer.
// Frame length depends on DESER_PARITY_EN: 8 data bits, plus an even-parity bit when it is defined.
// No logic here; consumed by demux18 and deserializer18.
package deser_pkg;

  localparam int WORD_W = 8;
  localparam int IDX_W  = 4;

`ifdef DESER_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  // Index of the bit that closes a frame (the parity bit when parity is enabled).
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } state_t;

endpackage

// File: rtl/demux18.sv
// Decodes the bit index plus accept strobe into one-hot write enables for the assembly register.
// Latency: purely combinational, zero cycles.
// Backpressure: none; an index beyond the data bits (the parity slot) enables nothing.
module demux18
  import deser_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [IDX_W-1:0]  idx,
  input  logic              accept,
  output logic [WORD_W-1:0] we
);

  // One enable per register bit; MSB-first mode mirrors the bit position.
  always_comb begin
    we = '0;
    for (int i = 0; i < WORD_W; i++) begin
      if (LSB_FIRST) begin
        we[i] = accept && (idx == IDX_W'(i));
      end else begin
        we[i] = accept && (idx == IDX_W'(WORD_W - 1 - i));
      end
    end
  end

endmodule

// File: rtl/deserializer18.sv
// Assembles serial bits into 8-bit words; optional even-parity check under macro DESER_PARITY_EN.
// Latency: completed word appears on out_data/out_valid 1 cycle after the final frame bit is accepted.
// Backpressure: in_ready drops only on the final frame bit while the held word is not being taken.
module deserializer18
  import deser_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready,
  output logic              parity_err
);

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] asm_next;
  logic [WORD_W-1:0] we;
  state_t            state;
  logic              at_last;
  logic              stall;
  logic              accept;
  logic              frame_done;

  // The final bit can only land if the holding register frees up this same cycle.
  assign at_last    = (idx == LAST_IDX);
  assign stall      = at_last && out_valid && !out_ready;
  // While parked in STALL the word is still held at the last index, so readiness tracks out_ready.
  assign in_ready   = (state == STALL) ? out_ready : !stall;
  assign accept     = in_valid && in_ready && !flush;
  assign frame_done = accept && at_last;

  demux18 #(.LSB_FIRST(LSB_FIRST)) u_demux (
    .idx    (idx),
    .accept (accept),
    .we     (we)
  );

  // Merge the incoming bit into its enabled slot; every other slot holds.
  assign asm_next = (asm_q & ~we) | (we & {WORD_W{in_bit}});

  // Bit index, assembly register and stall state; flush beats input acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      asm_q <= '0;
      state <= COLLECT;
    end else if (flush) begin
      idx   <= '0;
      asm_q <= '0;
      state <= COLLECT;
    end else begin
      asm_q <= asm_next;
      state <= stall ? STALL : COLLECT;
      if (accept) begin
        idx <= frame_done ? '0 : idx + 1'b1;
      end
    end
  end

  // Output holding register; a new word and a handshake in the same cycle keep out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (frame_done) begin
      out_valid <= 1'b1;
      out_data  <= asm_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DESER_PARITY_EN
  // Even parity over 8 data bits plus the parity bit, which is the one arriving now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (frame_done) begin
      parity_err <= (^asm_q) ^ in_bit;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer18.sv
// Self-checking bench: LSB-first and MSB-first instances share stimulus; a frame-level model predicts outputs.
// Latency: model expects each word one cycle after its last bit.
// Backpressure: model predicts in_ready from frame position, held-word state and out_ready.
module tb_deserializer18;

`ifdef DESER_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic       flush;
  logic       out_ready;
  logic       rdy_l, vld_l, perr_l;
  logic       rdy_m, vld_m, perr_m;
  logic [7:0] dat_l, dat_m;

  int npass  = 0;
  int ntotal = 0;

  // Reference model: bits of the frame in progress and the word waiting for the consumer.
  int         n;
  bit         bits[9];
  bit         mvld;
  logic [7:0] m_l, m_m;
  bit         mperr;

  deserializer18 #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_ready(rdy_l),
    .flush(flush), .out_valid(vld_l), .out_data(dat_l), .out_ready(out_ready), .parity_err(perr_l)
  );

  deserializer18 #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_ready(rdy_m),
    .flush(flush), .out_valid(vld_m), .out_data(dat_m), .out_ready(out_ready), .parity_err(perr_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [8:0] with_par(input logic [7:0] w);
    return {^w, w};
  endfunction

  task automatic model_reset();
    n     = 0;
    mvld  = 1'b0;
    m_l   = 8'h00;
    m_m   = 8'h00;
    mperr = 1'b0;
  endtask

  // One clock: drive inputs, check in_ready, advance model, check registered outputs. Starts/ends at negedge.
  task automatic cycle(input bit v, input bit b, input bit ordy, input bit fl);
    bit erdy, hs, acc, done;
    in_valid  = v;
    in_bit    = b;
    out_ready = ordy;
    flush     = fl;
    #1;
    erdy = !((n == FRAME - 1) && mvld && !ordy);
    chk("in_ready_lsb", rdy_l, erdy);
    chk("in_ready_msb", rdy_m, erdy);
    hs   = mvld && ordy;
    acc  = v && erdy && !fl;
    done = 1'b0;
    if (fl) begin
      n = 0;
    end else if (acc) begin
      bits[n] = b;
      n++;
      if (n == FRAME) begin
        done  = 1'b1;
        n     = 0;
        mvld  = 1'b1;
        m_l   = 8'h00;
        m_m   = 8'h00;
        mperr = 1'b0;
        for (int k = 0; k < 8; k++) begin
          m_l = m_l | (8'(bits[k]) << k);
          m_m = m_m | (8'(bits[k]) << (7 - k));
        end
`ifdef DESER_PARITY_EN
        for (int k = 0; k < 9; k++) mperr = mperr ^ bits[k];
`endif
      end
    end
    if (hs && !done) mvld = 1'b0;
    @(posedge clk);
    #1;
    chk("out_valid_lsb", vld_l, mvld);
    chk("out_valid_msb", vld_m, mvld);
    if (mvld) begin
      chk("out_data_lsb", dat_l, m_l);
      chk("out_data_msb", dat_m, m_m);
      chk("parity_err_lsb", perr_l, mperr);
      chk("parity_err_msb", perr_m, mperr);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [8:0] pat, input bit ordy);
    for (int k = 0; k < FRAME; k++) cycle(1'b1, pat[k], ordy, 1'b0);
  endtask

  initial begin
    logic [8:0] wa, wb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();

    // Reset state
    #3;
    chk("rst_out_valid", vld_l, 1'b0);
    chk("rst_out_data", dat_l, 8'h00);
    chk("rst_parity_err", perr_l, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", rdy_l, 1'b1);
    chk("rst_in_ready_msb", rdy_m, 1'b1);

    // Bit stream 1,0,1,1,0,0,1,0 -> 4D (LSB first) / B2 (MSB first)
    send(with_par(8'h4D), 1'b1);
    chk("stream_valid", vld_l, 1'b1);
    chk("stream_lsb_4d", dat_l, 8'h4D);
    chk("stream_msb_b2", dat_m, 8'hB2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("stream_valid_one_cycle", vld_l, 1'b0);

    // Back-to-back words with consumer stalled, then released
    wa = with_par(8'h3C);
    wb = with_par(8'hA5);
    send(wa, 1'b0);
    for (int k = 0; k < FRAME - 1; k++) cycle(1'b1, wb[k], 1'b0, 1'b0);
    cycle(1'b1, wb[FRAME-1], 1'b0, 1'b0);
    cycle(1'b1, wb[FRAME-1], 1'b0, 1'b0);
    in_valid = 1'b1; in_bit = wb[FRAME-1]; out_ready = 1'b0;
    #1;
    chk("stall_in_ready", rdy_l, 1'b0);
    chk("stall_word_a_held", dat_l, 8'h3C);
    @(negedge clk);
    cycle(1'b1, wb[FRAME-1], 1'b1, 1'b0);
    chk("b2b_valid_kept", vld_l, 1'b1);
    chk("b2b_word_b", dat_l, 8'hA5);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Flush after 3 bits (same-cycle bit ignored), then an all-ones frame
    for (int k = 0; k < 3; k++) cycle(1'b1, k[0], 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    send(with_par(8'hFF), 1'b1);
    chk("flush_word_ff", dat_l, 8'hFF);
    chk("flush_valid", vld_l, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-frame while a word is held
    send(with_par(8'h5A), 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", vld_l, 1'b0);
    chk("arst_out_data", dat_l, 8'h00);
    chk("arst_out_data_msb", dat_m, 8'h00);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(with_par(8'hC3), 1'b1);
    chk("arst_next_frame", dat_l, 8'hC3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef DESER_PARITY_EN
    send({1'b1, 8'h4D}, 1'b1);
    chk("parity_bad", perr_l, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    send({1'b0, 8'h4D}, 1'b1);
    chk("parity_good", perr_l, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
